// File: rtl/dff_bank_rr_arbiter_if.sv
// dff_bank_rr_arbiter_if
// Bundles the requester-facing signals of the shared-register arbiter.
//   req  : N     per-requester load request, held until the matching ack
//   din  : N*W   requester data, din[i*WIDTH +: WIDTH] belongs to requester i
//   gnt  : N     registered one-hot grant
//   ack  : N     one-cycle one-hot pulse marking a completed load
//   q    : W     contents of the shared register
//   busy : 1     arbiter is in the middle of a transaction
// The master modport is the requester side; the slave modport is the arbiter.
interface dff_bank_rr_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] din;
  logic [N-1:0]       gnt;
  logic [N-1:0]       ack;
  logic [WIDTH-1:0]   q;
  logic               busy;

  modport master (
    output req, din,
    input  gnt, ack, q, busy
  );

  modport slave (
    input  req, din,
    output gnt, ack, q, busy
  );
endinterface

// File: rtl/dff_bank_rr_arbiter.sv
// dff_bank_rr_arbiter
// Round-robin arbiter and write sequencer for a single shared WIDTH-bit
// register. All state lives in falling-edge flops. One requester is granted,
// its data is loaded into the register, an ack is pulsed, and priority then
// moves to the requester after the winner.
// Ports:
//   Clock : falling-edge clock for every flop
//   RST   : synchronous, active-high reset (sampled on the falling edge)
//   bus   : slave side of dff_bank_rr_arbiter_if (req/din in, gnt/ack/q/busy out)
module dff_bank_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic                   Clock,
  input  logic                   RST,
  dff_bank_rr_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic [N-1:0]       ack_q, ack_d;
  logic [WIDTH-1:0]   data_q, data_d;

  logic [WIDTH-1:0]   dinArr [N];
  logic               found;
  logic [PTR_W-1:0]   pick;
  logic [PTR_W:0]     candSum;

  // Unflatten the requester data bus so the winner's word can be picked by index.
  for (genvar g = 0; g < N; g++) begin : gUnpack
    assign dinArr[g] = bus.din[g*WIDTH +: WIDTH];
  end

  // Rotating priority search: look at ptr, ptr+1, ... wrapping modulo N and
  // take the first active request. The sum is one bit wider so a single
  // subtraction brings it back into 0..N-1 even when N is not a power of two.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    candSum = '0;
    for (int k = 0; k < N; k++) begin
      candSum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (candSum >= (PTR_W+1)'(N)) begin
        candSum = candSum - (PTR_W+1)'(N);
      end
      if (!found && bus.req[candSum[PTR_W-1:0]]) begin
        found = 1'b1;
        pick  = candSum[PTR_W-1:0];
      end
    end
  end

  // State and datapath registers; reset wins over any transaction in flight,
  // so a load that would have happened on this edge is simply dropped.
  always_ff @(negedge Clock) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic: GRANT falls back to IDLE if the winner withdrew its
  // request before the load edge, otherwise it always passes through DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = found ? GRANT : IDLE;
      GRANT:   state_d = bus.req[win_q] ? DONE : IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered output and datapath next values. The pointer only advances on
  // a completed load, so an aborted grant leaves priority where it was.
  always_comb begin
    ptr_d  = ptr_q;
    win_d  = win_q;
    gnt_d  = gnt_q;
    ack_d  = ack_q;
    data_d = data_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          win_d       = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
        end
      end
      GRANT: begin
        if (bus.req[win_q]) begin
          data_d       = dinArr[win_q];
          ack_d        = '0;
          ack_d[win_q] = 1'b1;
        end else begin
          gnt_d = '0;
        end
      end
      DONE: begin
        gnt_d = '0;
        ack_d = '0;
        ptr_d = (win_q == PTR_W'(N-1)) ? '0 : win_q + 1'b1;
      end
      default: begin
        gnt_d = '0;
        ack_d = '0;
      end
    endcase
  end

  assign bus.gnt  = gnt_q;
  assign bus.ack  = ack_q;
  assign bus.q    = data_q;
  assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_dff_bank_rr_arbiter.sv
// tb_dff_bank_rr_arbiter
// Directed self-checking bench for dff_bank_rr_arbiter. Inputs are driven on
// the rising edge and outputs sampled there, half a cycle away from the
// falling edge that updates the design.
module tb_dff_bank_rr_arbiter;

  localparam int WIDTH = 8;
  localparam int N     = 4;

  logic Clock;
  logic RST;
  int   checks;
  int   errors;

  dff_bank_rr_arbiter_if #(.WIDTH(WIDTH), .N(N)) bus ();

  dff_bank_rr_arbiter #(.WIDTH(WIDTH), .N(N), .PTR_W(2)) dut (
    .Clock (Clock),
    .RST   (RST),
    .bus   (bus)
  );

  // Free-running clock; the design acts on the falling edge.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Structural invariants watched every cycle: grant and ack never multi-hot,
  // and an ack is always accompanied by the matching grant.
  always @(posedge Clock) begin
    if (!RST) begin
      checks++;
      if (!$onehot0(bus.gnt) || !$onehot0(bus.ack) || ((bus.ack & ~bus.gnt) != '0)) begin
        errors++;
        $display("[TB] FAIL invariant t=%0t: gnt=%b ack=%b, required one-hot0 with ack inside gnt",
                 $time, bus.gnt, bus.ack);
      end
    end
  end

  // Short reset pulse between scenarios so each starts from ptr = 0.
  task automatic doReset();
    RST     = 1'b1;
    bus.req = '0;
    bus.din = '0;
    @(posedge Clock);
    RST = 1'b0;
  endtask

  // Reset held over two edges with every requester asking, then released.
  task automatic test_reset();
    RST     = 1'b1;
    bus.req = 4'b1111;
    bus.din = '0;
    @(posedge Clock);
    @(posedge Clock);
    checks++;
    if (bus.q !== 8'h00) begin errors++; $display("[TB] FAIL reset_q: got %h expected 00", bus.q); end
    checks++;
    if (bus.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected 0000", bus.gnt); end
    checks++;
    if (bus.ack !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 0000", bus.ack); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    RST = 1'b0;
    @(posedge Clock);
    checks++;
    if (bus.gnt !== 4'b0001) begin errors++; $display("[TB] FAIL reset_first_gnt: got %b expected 0001", bus.gnt); end
    bus.req = '0;
    @(posedge Clock);
    checks++;
    if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_release_abort: busy=%b gnt=%b expected busy=0 gnt=0000", bus.busy, bus.gnt);
    end
  endtask

  // One requester alone: grant, load with ack, then everything idles.
  task automatic test_single();
    doReset();
    bus.req = 4'b0100;
    bus.din[2*WIDTH +: WIDTH] = 8'hA5;
    @(posedge Clock);
    checks++;
    if (bus.gnt !== 4'b0100 || bus.busy !== 1'b1 || bus.ack !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL single_e0: gnt=%b busy=%b ack=%b expected 0100/1/0000", bus.gnt, bus.busy, bus.ack);
    end
    @(posedge Clock);
    checks++;
    if (bus.q !== 8'hA5 || bus.ack !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL single_e1: q=%h ack=%b expected a5/0100", bus.q, bus.ack);
    end
    bus.req = 4'b0000;
    @(posedge Clock);
    checks++;
    if (bus.gnt !== 4'b0000 || bus.ack !== 4'b0000 || bus.busy !== 1'b0 || bus.q !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL single_e2: gnt=%b ack=%b busy=%b q=%h expected 0000/0000/0/a5",
               bus.gnt, bus.ack, bus.busy, bus.q);
    end
  endtask

  // All four requesting; each drops after its ack and re-raises a cycle later.
  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] expOh;
    doReset();
    for (int i = 0; i < N; i++) bus.din[i*WIDTH +: WIDTH] = 8'(16 + i);
    bus.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      expOh = 4'(1 << order[n]);
      @(posedge Clock);
      checks++;
      if (bus.gnt !== expOh) begin
        errors++;
        $display("[TB] FAIL rr_gnt[%0d]: got %b expected %b", n, bus.gnt, expOh);
      end
      @(posedge Clock);
      checks++;
      if (bus.ack !== expOh || bus.q !== 8'(16 + order[n])) begin
        errors++;
        $display("[TB] FAIL rr_load[%0d]: ack=%b q=%h expected %b/%h", n, bus.ack, bus.q, expOh, 8'(16 + order[n]));
      end
      bus.req[order[n]] = 1'b0;
      @(posedge Clock);
      checks++;
      if (bus.gnt !== 4'b0000 || bus.ack !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL rr_done[%0d]: gnt=%b ack=%b expected 0000/0000", n, bus.gnt, bus.ack);
      end
      bus.req[order[n]] = 1'b1;
    end
    bus.req = '0;
    @(posedge Clock);
  endtask

  // After requester 3 wins the pointer wraps to 0, so 1 beats 3.
  task automatic test_wrap();
    doReset();
    bus.req = 4'b1000;
    bus.din[3*WIDTH +: WIDTH] = 8'h33;
    bus.din[1*WIDTH +: WIDTH] = 8'h21;
    @(posedge Clock);
    checks++;
    if (bus.gnt !== 4'b1000) begin errors++; $display("[TB] FAIL wrap_pre_gnt: got %b expected 1000", bus.gnt); end
    @(posedge Clock);
    bus.req = '0;
    @(posedge Clock);
    bus.req = 4'b1010;
    @(posedge Clock);
    checks++;
    if (bus.gnt !== 4'b0010) begin errors++; $display("[TB] FAIL wrap_first_gnt: got %b expected 0010", bus.gnt); end
    @(posedge Clock);
    checks++;
    if (bus.q !== 8'h21) begin errors++; $display("[TB] FAIL wrap_first_q: got %h expected 21", bus.q); end
    bus.req[1] = 1'b0;
    @(posedge Clock);
    @(posedge Clock);
    checks++;
    if (bus.gnt !== 4'b1000) begin errors++; $display("[TB] FAIL wrap_second_gnt: got %b expected 1000", bus.gnt); end
    @(posedge Clock);
    checks++;
    if (bus.q !== 8'h33) begin errors++; $display("[TB] FAIL wrap_second_q: got %h expected 33", bus.q); end
    bus.req = '0;
    @(posedge Clock);
  endtask

  // Winner withdraws in the GRANT cycle: no ack, q and pointer untouched.
  task automatic test_abort();
    doReset();
    bus.req = 4'b1000;
    bus.din[3*WIDTH +: WIDTH] = 8'h5A;
    @(posedge Clock);
    @(posedge Clock);
    checks++;
    if (bus.q !== 8'h5A) begin errors++; $display("[TB] FAIL abort_preload: got %h expected 5a", bus.q); end
    bus.req = '0;
    @(posedge Clock);
    bus.req = 4'b0001;
    bus.din[0*WIDTH +: WIDTH] = 8'h77;
    bus.din[1*WIDTH +: WIDTH] = 8'h88;
    @(posedge Clock);
    checks++;
    if (bus.gnt !== 4'b0001) begin errors++; $display("[TB] FAIL abort_gnt: got %b expected 0001", bus.gnt); end
    bus.req = 4'b0000;
    @(posedge Clock);
    checks++;
    if (bus.gnt !== 4'b0000 || bus.ack !== 4'b0000 || bus.q !== 8'h5A || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_result: gnt=%b ack=%b q=%h busy=%b expected 0000/0000/5a/0",
               bus.gnt, bus.ack, bus.q, bus.busy);
    end
    bus.req = 4'b0011;
    @(posedge Clock);
    checks++;
    if (bus.gnt !== 4'b0001) begin errors++; $display("[TB] FAIL abort_ptr_kept: got %b expected 0001", bus.gnt); end
    @(posedge Clock);
    checks++;
    if (bus.q !== 8'h77) begin errors++; $display("[TB] FAIL abort_after_q: got %h expected 77", bus.q); end
    bus.req = '0;
    @(posedge Clock);
  endtask

  // Reset during GRANT discards the load and returns the pointer to 0.
  task automatic test_reset_mid();
    doReset();
    bus.req = 4'b0100;
    bus.din[2*WIDTH +: WIDTH] = 8'h5A;
    @(posedge Clock);
    @(posedge Clock);
    bus.req = '0;
    @(posedge Clock);
    bus.req = 4'b0010;
    bus.din[1*WIDTH +: WIDTH] = 8'hFF;
    bus.din[3*WIDTH +: WIDTH] = 8'h3C;
    @(posedge Clock);
    checks++;
    if (bus.gnt !== 4'b0010) begin errors++; $display("[TB] FAIL rstmid_gnt: got %b expected 0010", bus.gnt); end
    RST = 1'b1;
    @(posedge Clock);
    checks++;
    if (bus.q !== 8'h00 || bus.gnt !== 4'b0000 || bus.ack !== 4'b0000 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_result: q=%h gnt=%b ack=%b busy=%b expected 00/0000/0000/0",
               bus.q, bus.gnt, bus.ack, bus.busy);
    end
    RST = 1'b0;
    bus.req = 4'b1010;
    @(posedge Clock);
    checks++;
    if (bus.gnt !== 4'b0010 || bus.ack !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL rstmid_ptr_zero: gnt=%b ack=%b expected 0010/0000", bus.gnt, bus.ack);
    end
    @(posedge Clock);
    checks++;
    if (bus.q !== 8'hFF) begin errors++; $display("[TB] FAIL rstmid_reload_q: got %h expected ff", bus.q); end
    bus.req = '0;
    @(posedge Clock);
  endtask

  // Scenario sequence and summary.
  initial begin
    checks  = 0;
    errors  = 0;
    RST     = 1'b1;
    bus.req = '0;
    bus.din = '0;
    @(posedge Clock);
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
